// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, GF(2^8) helpers and state typedefs
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int RK_IDX_W   = 4;

    // Byte b of the block lives at index [15-b], so byte 0 is bits [127:120].
    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } fsm_state_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes128_dec_iter_if.sv
// rtl/aes128_dec_iter_if.sv - block/key-store handshake bundle (abort present with AES_DEC_ABORT_EN)
interface aes128_dec_iter_if;
    import aes_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [127:0]        in_data;
    logic [RK_IDX_W-1:0] rk_idx;
    logic [127:0]        rk_key;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        out_data;
`ifdef AES_DEC_ABORT_EN
    logic                abort;

    modport slave (
        input  in_valid, in_data, rk_key, out_ready, abort,
        output in_ready, rk_idx, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, rk_key, out_ready, abort,
        input  in_ready, rk_idx, out_valid, out_data
    );
`else
    modport slave (
        input  in_valid, in_data, rk_key, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, rk_key, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );
`endif
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    input  aes_state_t rk_i,
    input  logic       last_i,
    output aes_state_t state_o
);
    logic [7:0] sr [16];
    logic [7:0] ak [16];
    logic [7:0] mc [16];

    // Row r rotates right by r columns: s'[r][c] = s[r][(c - r) mod 4].
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = state_i[15 - (4*((c + 4 - r) % 4) + r)];
            assign ak[4*c+r] = INV_SBOX[sr[4*c+r]] ^ rk_i[15 - (4*c + r)];
        end

        assign mc[4*c+0] = gf_mul(ak[4*c+0], 8'h0e) ^ gf_mul(ak[4*c+1], 8'h0b)
                         ^ gf_mul(ak[4*c+2], 8'h0d) ^ gf_mul(ak[4*c+3], 8'h09);
        assign mc[4*c+1] = gf_mul(ak[4*c+0], 8'h09) ^ gf_mul(ak[4*c+1], 8'h0e)
                         ^ gf_mul(ak[4*c+2], 8'h0b) ^ gf_mul(ak[4*c+3], 8'h0d);
        assign mc[4*c+2] = gf_mul(ak[4*c+0], 8'h0d) ^ gf_mul(ak[4*c+1], 8'h09)
                         ^ gf_mul(ak[4*c+2], 8'h0e) ^ gf_mul(ak[4*c+3], 8'h0b);
        assign mc[4*c+3] = gf_mul(ak[4*c+0], 8'h0b) ^ gf_mul(ak[4*c+1], 8'h0d)
                         ^ gf_mul(ak[4*c+2], 8'h09) ^ gf_mul(ak[4*c+3], 8'h0e);
    end

    for (genvar i = 0; i < 16; i++) begin : g_out
        assign state_o[15-i] = last_i ? ak[i] : mc[i];
    end

endmodule

// File: rtl/aes128_dec_iter.sv
// rtl/aes128_dec_iter.sv - iterative AES-128 decryptor, one round per clock; AES_DEC_ABORT_EN adds abort
module aes128_dec_iter
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    aes128_dec_iter_if.slave  bus
);
    localparam logic [RK_IDX_W-1:0] RK_LAST   = RK_IDX_W'(NUM_ROUNDS);
    localparam logic [RK_IDX_W-1:0] RND_FIRST = RK_IDX_W'(NUM_ROUNDS - 1);
    localparam logic [RK_IDX_W-1:0] RND_ONE   = RK_IDX_W'(1);

    fsm_state_e          state_q, state_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    aes_state_t          st_q, st_d;
    aes_state_t          round_out;
    logic                last_round;
    logic                abort_req;

`ifdef AES_DEC_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_round   = (state_q == ST_FINAL);
    assign bus.out_data = st_q;

    aes_inv_round u_round (
        .state_i (st_q),
        .rk_i    (bus.rk_key),
        .last_i  (last_round),
        .state_o (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rnd_d         = rnd_q;
        st_d          = st_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.rk_idx    = RK_LAST;
        case (state_q)
            ST_IDLE: begin
                // Abort outranks a pending block so no handshake is advertised.
                bus.in_ready = !abort_req;
                if (bus.in_valid && !abort_req) begin
                    st_d    = bus.in_data ^ bus.rk_key;
                    rnd_d   = RND_FIRST;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                bus.rk_idx = rnd_q;
                st_d       = round_out;
                if (rnd_q == RND_ONE) state_d = ST_FINAL;
                else                  rnd_d   = rnd_q - RND_ONE;
            end
            ST_FINAL: begin
                bus.rk_idx = '0;
                st_d       = round_out;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_req && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            rnd_d   = '0;
            st_d    = '0;
        end
    end

endmodule
